// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Single-frame SPI master (CPOL=0, MSB first, 1..32 bit frames) driving a
//   two-chip-select bus on behalf of the control register block.
//
//   Parameters
//     CLK_DIV              SCLK half-period in clk cycles (1..255)
//
//   Ports
//     clk, rstb            system clock, asynchronous active-low reset
//     spi_rw_len[4:0]      frame length minus one (N = spi_rw_len + 1)
//     spi_wdata[31:0]      transmit data, low N bits sent MSB first
//     spi_ch_sel           0: csb0/miso0, 1: csb1/miso1
//     spi_send_rise_align  1: launch MOSI on SCLK rise, 0: on SCLK fall
//     spi_rcv_rise_align   1: sample MISO on SCLK rise, 0: on SCLK fall
//     spi_wr_en/spi_rd_en  single-cycle transfer requests (both = read)
//     spi_busy             high from request until the post-frame gap ends
//     spi_rdata/rdata1     last channel-0 / channel-1 read result
//     sclk, csb0, csb1     SPI clock (idles low) and active-low selects
//     mosi, miso0, miso1   serial data out / in
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [4:0]  spi_rw_len,
  input  logic [31:0] spi_wdata,
  input  logic        spi_ch_sel,
  input  logic        spi_send_rise_align,
  input  logic        spi_rcv_rise_align,
  input  logic        spi_wr_en,
  input  logic        spi_rd_en,
  output logic        spi_busy,
  output logic [31:0] spi_rdata,
  output logic [31:0] spi_rdata1,
  output logic        sclk,
  output logic        csb0,
  output logic        csb1,
  output logic        mosi,
  input  logic        miso0,
  input  logic        miso1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Half-period counter reload value; the counter counts down to zero.
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bit_q, bit_d;
  logic [4:0]  len_q, len_d;
  logic        ch_q, ch_d;
  logic        srise_q, srise_d;
  logic        rrise_q, rrise_d;
  logic        rd_q, rd_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        sclk_q, sclk_d;
  logic        csb0_q, csb0_d;
  logic        csb1_q, csb1_d;
  logic        busy_q, busy_d;

  logic        start_s;
  logic        tick_s;
  logic        last_s;
  logic        miso_s;
  logic [31:0] mask_s;

  assign start_s = (spi_wr_en | spi_rd_en) & ~busy_q;
  assign tick_s  = (cnt_q == 8'd0);
  // Final falling edge of the frame: SCLK is high and all N bits have risen.
  assign last_s  = tick_s & sclk_q & (bit_q == len_q);
  assign miso_s  = ch_q ? miso1 : miso0;
  // N-bit mask; len_q = 31 keeps all 32 bits.
  assign mask_s  = 32'hFFFF_FFFF >> (5'd31 - len_q);

  assign spi_busy   = busy_q;
  assign spi_rdata  = rdata0_q;
  assign spi_rdata1 = rdata1_q;
  assign sclk       = sclk_q;
  assign csb0       = csb0_q;
  assign csb1       = csb1_q;
  assign mosi       = tx_q[31];

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_XFER;
        else         state_d = ST_IDLE;
      end
      ST_XFER: begin
        if (last_s) state_d = ST_HOLD;
        else        state_d = ST_XFER;
      end
      ST_HOLD: begin
        if (tick_s) state_d = ST_GAP;
        else        state_d = ST_HOLD;
      end
      ST_GAP: begin
        if (tick_s) state_d = ST_IDLE;
        else        state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    len_d    = len_q;
    ch_d     = ch_q;
    srise_d  = srise_q;
    rrise_d  = rrise_q;
    rd_d     = rd_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sclk_d   = sclk_q;
    csb0_d   = csb0_q;
    csb1_d   = csb1_q;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = DIV_M1;
        bit_d  = 5'd0;
        sclk_d = 1'b0;
        if (start_s) begin
          // Latch the whole configuration; later input changes are ignored.
          len_d   = spi_rw_len;
          ch_d    = spi_ch_sel;
          srise_d = spi_send_rise_align;
          rrise_d = spi_rcv_rise_align;
          rd_d    = spi_rd_en;
          tx_d    = spi_wdata << (5'd31 - spi_rw_len);
          rx_d    = 32'd0;
          csb0_d  = spi_ch_sel;
          csb1_d  = ~spi_ch_sel;
          busy_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_XFER: begin
        if (tick_s) begin
          cnt_d  = DIV_M1;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge. Bit 1 is already on mosi, so rise-aligned launch
            // only shifts from the second rising edge on.
            if (srise_q && (bit_q != 5'd0)) tx_d = {tx_q[30:0], 1'b0};
            else                            tx_d = tx_q;
            if (rrise_q) rx_d = {rx_q[30:0], miso_s};
            else         rx_d = rx_q;
          end else begin
            // Falling edge: one bit slot completes here.
            if (!srise_q) tx_d = {tx_q[30:0], 1'b0};
            else          tx_d = tx_q;
            if (!rrise_q) rx_d = {rx_q[30:0], miso_s};
            else          rx_d = rx_q;
            if (bit_q != len_q) bit_d = bit_q + 5'd1;
            else                bit_d = bit_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_HOLD: begin
        if (tick_s) begin
          cnt_d  = DIV_M1;
          csb0_d = 1'b1;
          csb1_d = 1'b1;
          tx_d   = 32'd0;
          if (rd_q) begin
            if (ch_q) rdata1_d = rx_q & mask_s;
            else      rdata0_d = rx_q & mask_s;
          end else begin
            rdata0_d = rdata0_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_GAP: begin
        if (tick_s) begin
          cnt_d  = DIV_M1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        cnt_d  = DIV_M1;
        sclk_d = 1'b0;
        csb0_d = 1'b1;
        csb1_d = 1'b1;
        busy_d = 1'b0;
        tx_d   = 32'd0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q    <= DIV_M1;
      bit_q    <= 5'd0;
      len_q    <= 5'd0;
      ch_q     <= 1'b0;
      srise_q  <= 1'b0;
      rrise_q  <= 1'b0;
      rd_q     <= 1'b0;
      tx_q     <= 32'd0;
      rx_q     <= 32'd0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
      sclk_q   <= 1'b0;
      csb0_q   <= 1'b1;
      csb1_q   <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      len_q    <= len_d;
      ch_q     <= ch_d;
      srise_q  <= srise_d;
      rrise_q  <= rrise_d;
      rd_q     <= rd_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      sclk_q   <= sclk_d;
      csb0_q   <= csb0_d;
      csb1_q   <= csb1_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Randomized and directed transfers against a transaction-level model:
//   expected MOSI bits, SCLK edge times, busy length and read results are
//   computed from the frame rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rstb;
  logic [4:0]  spi_rw_len;
  logic [31:0] spi_wdata;
  logic        spi_ch_sel;
  logic        spi_send_rise_align;
  logic        spi_rcv_rise_align;
  logic        spi_wr_en;
  logic        spi_rd_en;
  logic        spi_busy;
  logic [31:0] spi_rdata;
  logic [31:0] spi_rdata1;
  logic        sclk;
  logic        csb0;
  logic        csb1;
  logic        mosi;
  logic        miso0_drv;
  logic        miso1_drv;
  logic        loop_en;
  logic        miso0_s;

  // Second instance with CLK_DIV=1 for the minimum-timing case.
  logic        wr_en_u1;
  logic        rd_en_u1;
  logic        busy_u1;
  logic [31:0] rdata_u1;
  logic [31:0] rdata1_u1;
  logic        sclk_u1;
  logic        csb0_u1;
  logic        csb1_u1;
  logic        mosi_u1;

  logic [31:0] exp_rd0;
  logic [31:0] exp_rd1;
  int          n_checks = 0;
  int          n_fail = 0;

  assign miso0_s = loop_en ? mosi : miso0_drv;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(H)) u_dut (
    .clk(clk), .rstb(rstb),
    .spi_rw_len(spi_rw_len), .spi_wdata(spi_wdata), .spi_ch_sel(spi_ch_sel),
    .spi_send_rise_align(spi_send_rise_align), .spi_rcv_rise_align(spi_rcv_rise_align),
    .spi_wr_en(spi_wr_en), .spi_rd_en(spi_rd_en),
    .spi_busy(spi_busy), .spi_rdata(spi_rdata), .spi_rdata1(spi_rdata1),
    .sclk(sclk), .csb0(csb0), .csb1(csb1), .mosi(mosi),
    .miso0(miso0_s), .miso1(miso1_drv)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .rstb(rstb),
    .spi_rw_len(spi_rw_len), .spi_wdata(spi_wdata), .spi_ch_sel(spi_ch_sel),
    .spi_send_rise_align(spi_send_rise_align), .spi_rcv_rise_align(spi_rcv_rise_align),
    .spi_wr_en(wr_en_u1), .spi_rd_en(rd_en_u1),
    .spi_busy(busy_u1), .spi_rdata(rdata_u1), .spi_rdata1(rdata1_u1),
    .sclk(sclk_u1), .csb0(csb0_u1), .csb1(csb1_u1), .mosi(mosi_u1),
    .miso0(1'b1), .miso1(1'b0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One complete transfer on u_dut with a slave model driving the selected
  // MISO (the other MISO carries the inverted bit to expose channel mixups).
  task automatic run_xfer(input logic rd, input logic wr, input logic [4:0] len,
                          input logic [31:0] wd, input logic ch, input logic sr,
                          input logic rr, input logic [31:0] sd, input logic loop,
                          input logic poke);
    int n, rises, falls, idx, cs_off, busy_len, t_err, rd_err, idle_err, unsel_err;
    logic [31:0] mask, mosi_cap, old0, old1, new0, new1;
    logic prev_sclk, sel_csb, unsel_csb, bitv;
    n    = int'(len) + 1;
    mask = 32'hFFFF_FFFF >> (32 - n);
    old0 = exp_rd0;
    old1 = exp_rd1;
    new0 = old0;
    new1 = old1;
    if (rd) begin
      if (ch) new1 = (loop ? wd : sd) & mask;
      else    new0 = (loop ? wd : sd) & mask;
    end
    @(negedge clk);
    spi_rw_len = len; spi_wdata = wd; spi_ch_sel = ch;
    spi_send_rise_align = sr; spi_rcv_rise_align = rr;
    spi_wr_en = wr; spi_rd_en = rd; loop_en = loop;
    idx  = 1;
    bitv = sd[n-1];
    miso0_drv = ch ? ~bitv : bitv;
    miso1_drv = ch ? bitv : ~bitv;
    @(negedge clk);
    spi_wr_en = 1'b0; spi_rd_en = 1'b0;
    // Scramble configuration: the transfer in flight must not notice.
    spi_rw_len = 5'($urandom); spi_wdata = $urandom; spi_ch_sel = ~ch;
    spi_send_rise_align = ~sr; spi_rcv_rise_align = ~rr;
    prev_sclk = 1'b0; rises = 0; falls = 0; cs_off = -1; busy_len = -1;
    t_err = 0; rd_err = 0; idle_err = 0; unsel_err = 0; mosi_cap = 32'd0;
    for (int m = 0; m < (2*n+2)*H + 8; m++) begin
      sel_csb   = ch ? csb1 : csb0;
      unsel_csb = ch ? csb0 : csb1;
      if (unsel_csb !== 1'b1) unsel_err++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        rises++;
        mosi_cap = {mosi_cap[30:0], mosi};
        if (m != (2*rises-1)*H) t_err++;
        if (!rr) idx = rises;
      end else if (sclk === 1'b0 && prev_sclk === 1'b1) begin
        falls++;
        if (m != 2*falls*H) t_err++;
        if (rr) idx = falls + 1;
      end
      prev_sclk = sclk;
      if (cs_off < 0 && sel_csb === 1'b1) cs_off = m;
      if (cs_off >= 0 && mosi !== 1'b0) idle_err++;
      if (m >= (2*n+1)*H) begin
        if (spi_rdata !== new0 || spi_rdata1 !== new1) rd_err++;
      end else begin
        if (spi_rdata !== old0 || spi_rdata1 !== old1) rd_err++;
      end
      if (spi_busy !== 1'b1) begin
        busy_len = m;
        break;
      end
      if (poke && m == 2) spi_wr_en = 1'b1;
      if (poke && m == 3) spi_wr_en = 1'b0;
      bitv = (idx >= 1 && idx <= n) ? sd[n-idx] : 1'b0;
      miso0_drv = ch ? ~bitv : bitv;
      miso1_drv = ch ? bitv : ~bitv;
      @(negedge clk);
    end
    spi_wr_en = 1'b0;
    check("rises", rises, n);
    check("falls", falls, n);
    check("mosi_bits", mosi_cap & mask, wd & mask);
    check("busy_len", busy_len, (2*n+2)*H);
    check("cs_deassert", cs_off, (2*n+1)*H);
    check("edge_timing_errs", t_err, 0);
    check("unsel_cs_errs", unsel_err, 0);
    check("mosi_idle_errs", idle_err, 0);
    check("rdata_timing_errs", rd_err, 0);
    check("rdata0", spi_rdata, new0);
    check("rdata1", spi_rdata1, new1);
    repeat (3) @(negedge clk);
    check("quiet_after", {27'd0, spi_busy, csb0, csb1, sclk, mosi}, 32'b01100);
    exp_rd0 = new0;
    exp_rd1 = new1;
    loop_en = 1'b0;
  endtask

  // Asserts reset right after the fifth rising SCLK edge of a 16-bit write.
  task automatic reset_mid_frame();
    int rises;
    logic prev;
    rises = 0;
    prev  = 1'b0;
    @(negedge clk);
    spi_rw_len = 5'd15; spi_wdata = $urandom; spi_ch_sel = 1'b0;
    spi_send_rise_align = 1'b0; spi_rcv_rise_align = 1'b1; spi_wr_en = 1'b1;
    @(negedge clk);
    spi_wr_en = 1'b0;
    for (int m = 0; m < 200 && rises < 5; m++) begin
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      if (rises < 5) @(negedge clk);
    end
    check("rst_reached_r5", rises, 5);
    rstb = 1'b0;
    #1;
    check("rst_async_busy", {31'd0, spi_busy}, 32'd0);
    check("rst_async_rdata", spi_rdata, 32'd0);
    check("rst_async_rdata1", spi_rdata1, 32'd0);
    check("rst_async_pins", {28'd0, sclk, csb0, csb1, mosi}, 32'b0110);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    exp_rd0 = 32'd0;
    exp_rd1 = 32'd0;
  endtask

  // CLK_DIV=1, N=1 read on the second instance: busy for exactly 4 cycles.
  task automatic div1_test();
    int cnt, rises;
    logic prev;
    cnt = 0; rises = 0; prev = 1'b0;
    @(negedge clk);
    spi_rw_len = 5'd0; spi_ch_sel = 1'b0;
    spi_send_rise_align = 1'b0; spi_rcv_rise_align = 1'b1; rd_en_u1 = 1'b1;
    @(negedge clk);
    rd_en_u1 = 1'b0;
    while (busy_u1 === 1'b1 && cnt < 50) begin
      if (sclk_u1 === 1'b1 && prev === 1'b0) rises++;
      prev = sclk_u1;
      cnt++;
      @(negedge clk);
    end
    check("div1_busy_len", cnt, 4);
    check("div1_pulses", rises, 1);
    check("div1_rdata", rdata_u1, 32'd1);
    check("div1_rdata1", rdata1_u1, 32'd0);
  endtask

  initial begin
    rstb = 1'b0;
    spi_rw_len = 5'd0; spi_wdata = 32'd0; spi_ch_sel = 1'b0;
    spi_send_rise_align = 1'b0; spi_rcv_rise_align = 1'b0;
    spi_wr_en = 1'b0; spi_rd_en = 1'b0;
    miso0_drv = 1'b0; miso1_drv = 1'b0; loop_en = 1'b0;
    wr_en_u1 = 1'b0; rd_en_u1 = 1'b0;
    exp_rd0 = 32'd0; exp_rd1 = 32'd0;
    #12;
    check("reset_busy", {31'd0, spi_busy}, 32'd0);
    check("reset_rdata", spi_rdata, 32'd0);
    check("reset_rdata1", spi_rdata1, 32'd0);
    check("reset_pins", {28'd0, sclk, csb0, csb1, mosi}, 32'b0110);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    // Byte write 0xA5, channel 0, falling-edge launch.
    run_xfer(1'b0, 1'b1, 5'd7, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
    // 16-bit read on channel 1, slave changes on falling edges.
    run_xfer(1'b1, 1'b0, 5'd15, $urandom, 1'b1, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    // Falling-edge sampling, slave changes on rising edges.
    run_xfer(1'b1, 1'b0, 5'd7, $urandom, 1'b0, 1'b1, 1'b0, 32'h0000_003C, 1'b0, 1'b0);
    // 32-bit loopback.
    run_xfer(1'b1, 1'b0, 5'd31, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
    // Write request while busy is dropped.
    run_xfer(1'b0, 1'b1, 5'd7, $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    // Write and read together act as a read.
    run_xfer(1'b1, 1'b1, 5'd11, $urandom, 1'b1, 1'b1, 1'b1, 32'h0000_05A5, 1'b0, 1'b0);
    // Single-bit frame.
    run_xfer(1'b1, 1'b0, 5'd0, $urandom, 1'b0, 1'b0, 1'b1, 32'h1, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      int op;
      op = $urandom_range(0, 2);
      run_xfer(op != 0, op != 1, 5'($urandom_range(0, 31)), $urandom,
               1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'b0, 1'($urandom));
    end

    reset_mid_frame();
    run_xfer(1'b0, 1'b1, 5'd7, $urandom, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    div1_test();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
